// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding, channel index and select-width helper for the perf counter bank
package perf_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_e;
    localparam int CH_CYCLE = 0;
    function automatic int sel_w(input int num_evt);
        return $clog2(num_evt + 1);
    endfunction
endpackage

// File: rtl/perf_counter.sv
// perf_counter: one event counter with clear, saturate-or-wrap increment and sticky overflow flag
module perf_counter import perf_pkg::*; #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d, at_max;
    always_comb begin
        at_max = &cnt_q;
        cnt_d  = clr_i ? '0 : (inc_i && !(at_max && SATURATE != 0)) ? cnt_q + CNT_W'(1) : cnt_q;
        ovf_d  = !clr_i && (ovf_q || (inc_i && at_max));
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle counter plus NUM_EVT event counters with run/freeze control and one-cycle readout
module perf_counter_bank import perf_pkg::*; #(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    localparam int SEL_W   = sel_w(NUM_EVT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    input  logic               rd_valid,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               rd_ready,
    output logic               rd_data_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic               frozen,
    output logic [NUM_EVT:0]   ovf
);
    state_e state_q;
    logic frozen_q, rd_dv_q, accept;
    logic [CNT_W-1:0] rd_data_q, rd_data_d, sel_val;
    logic [CNT_W-1:0] cnt [NUM_EVT+1];
    logic [NUM_EVT:0] inc;
    // channel CH_CYCLE counts every RUN cycle, the rest follow their event line
    assign inc = (state_q == RUN) ? {evt, 1'b1} : '0;
    for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clr_i(clr),
            .inc_i(inc[g]),
            .cnt_o(cnt[g]),
            .ovf_o(ovf[g])
        );
    end
    always_comb begin
        sel_val = '0;
        for (int k = 0; k <= NUM_EVT; k++) sel_val = (rd_sel == SEL_W'(k)) ? cnt[k] : sel_val;
        accept    = rd_valid && !clr;
        rd_data_d = accept ? sel_val : rd_data_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            frozen_q  <= 1'b0;
            rd_dv_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_dv_q   <= accept;
            rd_data_q <= rd_data_d;
            if (clr) begin
                state_q  <= IDLE;
                frozen_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (en) state_q <= RUN;
                    RUN: begin
                        if (halt) begin
                            state_q  <= FROZEN;
                            frozen_q <= 1'b1;
                        end else if (!en) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= FROZEN;
                endcase
            end
        end
    end
    assign rd_ready      = !clr;
    assign rd_data_valid = rd_dv_q;
    assign rd_data       = rd_data_q;
    assign frozen        = frozen_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed checks of run/halt, overflow, collisions, pause and reset on saturating and wrapping banks
module tb_perf_counter_bank;
    logic clk = 0, rst = 0, en = 0, clr = 0, halt = 0, rd_valid = 0;
    logic [3:0] evt = '0;
    logic [2:0] rd_sel = '0;
    logic s_rdy, s_dv, s_frozen, w_rdy, w_dv, w_frozen;
    logic [7:0] s_data, w_data;
    logic [4:0] s_ovf, w_ovf;
    int n_chk = 0, n_fail = 0;

    perf_counter_bank #(.NUM_EVT(4), .CNT_W(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
        .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_ready(s_rdy), .rd_data_valid(s_dv),
        .rd_data(s_data), .frozen(s_frozen), .ovf(s_ovf)
    );
    perf_counter_bank #(.NUM_EVT(4), .CNT_W(8), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
        .rd_valid(rd_valid), .rd_sel(rd_sel), .rd_ready(w_rdy), .rd_data_valid(w_dv),
        .rd_data(w_data), .frozen(w_frozen), .ovf(w_ovf)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic rd(input int sel);
        rd_valid = 1;
        rd_sel   = 3'(sel);
        step();
        rd_valid = 0;
    endtask

    task automatic rd_chk(input string tag, input int sel, input logic [31:0] exp);
        rd(sel);
        chk({tag, "_dv"}, 32'(s_dv), 1);
        chk(tag, 32'(s_data), exp);
    endtask

    initial begin
        step(2);
        chk("rst_frozen", 32'(s_frozen), 0);
        chk("rst_dv", 32'(s_dv), 0);
        chk("rst_data", 32'(s_data), 0);
        chk("rst_ovf", 32'(s_ovf), 0);
        chk("rst_ready", 32'(s_rdy), 1);
        rst = 1;
        // run and halt on the tenth RUN cycle
        en = 1;
        step();
        for (int c = 1; c <= 10; c++) begin
            evt  = {2'b00, c[0], 1'b1};
            halt = (c == 10);
            step();
        end
        halt = 0;
        evt  = 4'hf;
        en   = 0;
        step(3);
        evt = '0;
        chk("halt_frozen", 32'(s_frozen), 1);
        rd_chk("halt_sel7", 7, 0);
        rd_chk("halt_sel0", 0, 10);
        rd_chk("halt_sel1", 1, 10);
        rd_chk("halt_sel2", 2, 5);
        step();
        chk("hold_dv", 32'(s_dv), 0);
        chk("hold_data", 32'(s_data), 5);
        clr = 1;
        #1;
        chk("clr_ready", 32'(s_rdy), 0);
        step();
        clr = 0;
        chk("unfreeze", 32'(s_frozen), 0);
        // clr and halt together in RUN
        en = 1;
        step();
        evt = 4'b0001;
        step(3);
        clr  = 1;
        halt = 1;
        step();
        clr  = 0;
        halt = 0;
        en   = 0;
        evt  = '0;
        step();
        chk("clrhalt_frozen", 32'(s_frozen), 0);
        chk("clrhalt_ovf", 32'(s_ovf), 0);
        for (int k = 0; k <= 4; k++) rd_chk("clrhalt_rd", k, 0);
        // read/increment collision
        en = 1;
        step();
        evt = 4'b0001;
        step(7);
        rd(1);
        evt = '0;
        chk("coll_dv", 32'(s_dv), 1);
        chk("coll_first", 32'(s_data), 7);
        rd_chk("coll_next", 1, 8);
        // pause: the en=0 cycle is still RUN, then five idle cycles in total
        en  = 0;
        evt = 4'b0001;
        step(3);
        rd_chk("pause_c0", 0, 10);
        rd_chk("pause_c1", 1, 9);
        evt = '0;
        // overflow on channel 3 (evt[2]) and on the cycle counter
        clr = 1;
        step();
        clr = 0;
        en  = 1;
        step();
        evt = 4'b0100;
        step(300);
        evt = '0;
        en  = 0;
        step();
        chk("ovf_sat_flags", 32'(s_ovf), 32'h09);
        chk("ovf_wrap_flags", 32'(w_ovf), 32'h09);
        rd(3);
        chk("ovf_sat_sel3", 32'(s_data), 255);
        chk("ovf_wrap_sel3", 32'(w_data), 44);
        rd(0);
        chk("ovf_sat_sel0", 32'(s_data), 255);
        chk("ovf_wrap_sel0", 32'(w_data), 45);
        step(2);
        chk("ovf_sticky", 32'(s_ovf), 32'h09);
        clr = 1;
        step();
        clr = 0;
        chk("ovf_clr_sat", 32'(s_ovf), 0);
        chk("ovf_clr_wrap", 32'(w_ovf), 0);
        // reset arriving on the edge of a read request
        en = 1;
        step();
        evt = 4'hf;
        step(3);
        evt = '0;
        en  = 0;
        step();
        rd_chk("prerst_sel1", 1, 3);
        rd_valid = 1;
        rd_sel   = 3'd2;
        rst      = 0;
        step();
        rd_valid = 0;
        chk("rstrd_dv0", 32'(s_dv), 0);
        step();
        chk("rstrd_dv1", 32'(s_dv), 0);
        chk("rstrd_data", 32'(s_data), 0);
        rst = 1;
        for (int k = 0; k <= 4; k++) rd_chk("rstrd_rd", k, 0);
        chk("rstrd_frozen", 32'(s_frozen), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
